// File: rtl/simon_pkg.sv
// Purpose: shared constants and types for the object ROM and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simon_pkg;

   // object_mem geometry: 3-bit pixel words, 64 entries
   localparam int OBJ_MEM_N  = 3;
   localparam int OBJ_MEM_MN = 6;

   // renderer, pad animator, attract sequencer, one spare
   localparam int OBJMEM_ARB_N_REQ = 4;

   typedef logic [OBJ_MEM_MN-1:0] obj_addr_t;
   typedef logic [OBJ_MEM_N-1:0]  obj_pix_t;

endpackage

// File: rtl/object_mem_arbiter_rr_pick.sv
// Purpose: N-way circular priority picker; first set bit of elig at or after ptr.
// Latency: purely combinational.
// Backpressure: none; found=0 when elig is empty.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  elig,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] win_idx,
   output logic          found
);

   // scan offsets from farthest to nearest so the nearest eligible index wins
   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (elig[(int'(ptr) + k) % N]) begin
            found   = 1'b1;
            win_idx = PW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/object_mem_arbiter.sv
// Purpose: round-robin sharing of one object ROM; OBJMEM_ARB_VGA_PRIO_EN gives requester 0 absolute priority.
// Latency: req sampled in T -> gnt in T+1 -> rvalid/rdata in T+2.
// Backpressure: none; one ROM read per cycle, a requester is ineligible during its own gnt cycle.
module object_mem_arbiter
   import simon_pkg::*;
#(
   parameter int N_REQ = OBJMEM_ARB_N_REQ,
   parameter int n     = OBJ_MEM_N,
   parameter int Mn    = OBJ_MEM_MN
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*Mn-1:0] addr,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    rvalid,
   output logic [n-1:0]        rdata,
   output logic [Mn-1:0]       rom_address,
   input  logic [n-1:0]        rom_q
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [PW-1:0]    ptr_q, ptr_d;
   logic             s1_vld_q, s1_vld_d;
   logic [PW-1:0]    s1_idx_q, s1_idx_d;
   logic             s2_vld_q, s2_vld_d;
   logic [PW-1:0]    s2_idx_q, s2_idx_d;
   logic [n-1:0]     rdata_q, rdata_d;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] rr_elig;
   logic [PW-1:0]    rr_win;
   logic             rr_found;
   logic [PW-1:0]    win_idx;
   logic             win_found;
   logic             ptr_upd;

   // the requester holding gnt this cycle must not be picked again
   assign elig = req & ~gnt;

`ifdef OBJMEM_ARB_VGA_PRIO_EN
   // requester 0 is served by the priority override, so the rotation only sees 1..N_REQ-1
   assign rr_elig = elig & ~ONE;
`else
   assign rr_elig = elig;
`endif

   rr_pick #(
      .N  (N_REQ),
      .PW (PW)
   ) u_rr_pick (
      .elig    (rr_elig),
      .ptr     (ptr_q),
      .win_idx (rr_win),
      .found   (rr_found)
   );

   // final winner selection; the VGA override never moves the rotation pointer
   always_comb begin
      win_idx   = rr_win;
      win_found = rr_found;
      ptr_upd   = rr_found;
`ifdef OBJMEM_ARB_VGA_PRIO_EN
      if (elig[0]) begin
         win_idx   = '0;
         win_found = 1'b1;
         ptr_upd   = 1'b0;
      end
`endif
   end

   // next state: pointer, tag pipeline, and returned ROM word
   always_comb begin
      ptr_d    = ptr_q;
      if (ptr_upd) begin
         ptr_d = PW'((int'(win_idx) + 1) % N_REQ);
      end
      s1_vld_d = win_found;
      s1_idx_d = win_idx;
      s2_vld_d = s1_vld_q;
      s2_idx_d = s1_idx_q;
      // ROM output is valid the cycle after the address was registered; hold otherwise
      rdata_d  = s1_vld_q ? rom_q : rdata_q;
   end

   // state registers; reset drops any reads in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q    <= '0;
         s1_vld_q <= 1'b0;
         s1_idx_q <= '0;
         s2_vld_q <= 1'b0;
         s2_idx_q <= '0;
         rdata_q  <= '0;
      end else begin
         ptr_q    <= ptr_d;
         s1_vld_q <= s1_vld_d;
         s1_idx_q <= s1_idx_d;
         s2_vld_q <= s2_vld_d;
         s2_idx_q <= s2_idx_d;
         rdata_q  <= rdata_d;
      end
   end

   // outputs: ROM address for this cycle's winner, one-hot pulses decoded from the tags
   always_comb begin
      rom_address = '0;
      if (win_found) begin
         rom_address = addr[int'(win_idx)*Mn +: Mn];
      end
      gnt    = s1_vld_q ? (ONE << s1_idx_q) : '0;
      rvalid = s2_vld_q ? (ONE << s2_idx_q) : '0;
      rdata  = rdata_q;
   end

endmodule

// File: tb/tb_object_mem_arbiter.sv
// Purpose: directed self-checking bench for object_mem_arbiter with a behavioural object ROM.
// Latency: checks gnt one cycle and rvalid/rdata two cycles after the request is sampled.
// Backpressure: none modelled; requesters follow the hold-until-gnt contract.
module tb_object_mem_arbiter;
   import simon_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req   = '0;
   logic [23:0] addr  = '0;
   logic [3:0]  gnt;
   logic [3:0]  rvalid;
   logic [2:0]  rdata;
   logic [5:0]  rom_address;
   logic [2:0]  rom_q;
   logic [5:0]  rom_addr_q;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   // ROM contents: word[a] = (3a + 7) mod 8, so word[5] = 3'b110
   function automatic logic [2:0] rom_word(input logic [5:0] a);
      logic [7:0] t;
      t = {2'b00, a} * 8'd3 + 8'd7;
      return t[2:0];
   endfunction

   // object_mem model: registered address, combinational read
   always_ff @(posedge clock) rom_addr_q <= rom_address;
   assign rom_q = rom_word(rom_addr_q);

   object_mem_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .addr        (addr),
      .gnt         (gnt),
      .rvalid      (rvalid),
      .rdata       (rdata),
      .rom_address (rom_address),
      .rom_q       (rom_q)
   );

   // expected winner order with all four requesters held high
   function automatic int exp_w(input int k);
`ifdef OBJMEM_ARB_VGA_PRIO_EN
      return (k % 2 == 0) ? 0 : 1 + ((k - 1) / 2) % 3;
`else
      return k % 4;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      step();
      step();
      reset = 1'b0;
      chk("rst_gnt",    32'(gnt),         32'h0);
      chk("rst_rvalid", 32'(rvalid),      32'h0);
      chk("rst_rdata",  32'(rdata),       32'h0);
      chk("rst_raddr",  32'(rom_address), 32'h0);
   endtask

   initial begin
      // ---- single read by requester 0
      do_reset();
      req = 4'b0001;
      addr[0 +: 6] = 6'h05;
      #1;
      chk("t1_raddr", 32'(rom_address), 32'h05);
      step();
      chk("t1_gnt",    32'(gnt),    32'h1);
      chk("t1_rv0",    32'(rvalid), 32'h0);
      req = 4'b0000;
      #1;
      chk("t1_idle_raddr", 32'(rom_address), 32'h0);
      step();
      chk("t1_gnt_off", 32'(gnt),    32'h0);
      chk("t1_rvalid",  32'(rvalid), 32'h1);
      chk("t1_rdata",   32'(rdata),  32'h6);

      // ---- all four requesters held: rotation and pointer wrap
      do_reset();
      for (int i = 0; i < 4; i++) addr[i*6 +: 6] = 6'(8 + i);
      req = 4'b1111;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk("t2_raddr", 32'(rom_address), 32'(8 + exp_w(k)));
         step();
         chk("t2_gnt", 32'(gnt), 32'(1 << exp_w(k)));
         if (k >= 1) begin
            chk("t2_rvalid", 32'(rvalid), 32'(1 << exp_w(k - 1)));
            chk("t2_rdata",  32'(rdata),  32'(rom_word(6'(8 + exp_w(k - 1)))));
         end
      end
      req = 4'b0000;
      #1;
      chk("t2_idle_raddr", 32'(rom_address), 32'h0);
      step();
      chk("t2_tail_gnt",    32'(gnt),    32'h0);
      chk("t2_tail_rvalid", 32'(rvalid), 32'(1 << exp_w(11)));
      chk("t2_tail_rdata",  32'(rdata),  32'(rom_word(6'(8 + exp_w(11)))));
      step();
      chk("t2_end_rvalid", 32'(rvalid), 32'h0);
      chk("t2_hold_rdata", 32'(rdata),  32'(rom_word(6'(8 + exp_w(11)))));

      // ---- requester 2 alone stepping through addresses 0..7
      do_reset();
      for (int j = 0; j < 8; j++) begin
         req = 4'b0100;
         addr[12 +: 6] = 6'(j);
         #1;
         chk("t3_raddr", 32'(rom_address), 32'(j));
         step();
         chk("t3_gnt",    32'(gnt),    32'h4);
         chk("t3_rv_gap", 32'(rvalid), 32'h0);
         if (j == 7) req = 4'b0000;
         #1;
         chk("t3_gap_raddr", 32'(rom_address), 32'h0);
         step();
         chk("t3_gnt_gap", 32'(gnt),    32'h0);
         chk("t3_rvalid",  32'(rvalid), 32'h4);
         chk("t3_rdata",   32'(rdata),  32'(rom_word(6'(j))));
      end

      // ---- reset during the gnt cycle of a read by requester 1
      do_reset();
      req = 4'b0010;
      addr[6 +: 6] = 6'h21;
      #1;
      chk("t4_raddr", 32'(rom_address), 32'h21);
      step();
      chk("t4_gnt", 32'(gnt), 32'h2);
      reset = 1'b1;
      req   = 4'b0000;
      step();
      chk("t4_drop_gnt",    32'(gnt),    32'h0);
      chk("t4_drop_rvalid", 32'(rvalid), 32'h0);
      chk("t4_drop_rdata",  32'(rdata),  32'h0);
      reset = 1'b0;
      req   = 4'b1010;
      addr[6 +: 6]  = 6'h11;
      addr[18 +: 6] = 6'h33;
      #1;
      chk("t4_first_raddr", 32'(rom_address), 32'h11);
      step();
      chk("t4_first_gnt", 32'(gnt),    32'h2);
      chk("t4_no_rvalid", 32'(rvalid), 32'h0);
      req = 4'b1000;
      #1;
      chk("t4_second_raddr", 32'(rom_address), 32'h33);
      step();
      chk("t4_second_gnt", 32'(gnt),    32'h8);
      chk("t4_rvalid1",    32'(rvalid), 32'h2);
      chk("t4_rdata1",     32'(rdata),  32'(rom_word(6'h11)));
      req = 4'b0000;
      step();
      chk("t4_gnt_off", 32'(gnt),    32'h0);
      chk("t4_rvalid3", 32'(rvalid), 32'h8);
      chk("t4_rdata3",  32'(rdata),  32'(rom_word(6'h33)));
      step();
      chk("t4_rv_end",  32'(rvalid), 32'h0);
      chk("t4_rd_hold", 32'(rdata),  32'(rom_word(6'h33)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
